// File: rtl/polara_loopback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : polara_loopback_pkg
// Purpose : Shared constants and types for the Polara loopback packet
//           generator and checker: NoC header field positions, expected
//           chip ID, message type, march payload length and FSM states.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package polara_loopback_pkg;

  // NoC header field positions
  localparam int HDR_CHIPID_MSB = 63;
  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_X_MSB      = 49;
  localparam int HDR_X_LSB      = 42;
  localparam int HDR_Y_MSB      = 41;
  localparam int HDR_Y_LSB      = 34;
  localparam int HDR_FBITS_MSB  = 33;
  localparam int HDR_FBITS_LSB  = 30;
  localparam int HDR_LEN_MSB    = 29;
  localparam int HDR_LEN_LSB    = 22;
  localparam int HDR_TYPE_MSB   = 21;
  localparam int HDR_TYPE_LSB   = 14;
  localparam int HDR_MSHR_MSB   = 13;
  localparam int HDR_MSHR_LSB   = 6;

  localparam logic [13:0] EXP_CHIPID         = 14'b10000000000000;
  localparam logic [7:0]  MSG_TYPE_INV_FWD   = 8'd18;
  localparam logic [7:0]  LOOPBACK_MARCH_LEN = 8'd65;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/polara_loopback_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : polara_loopback_pattern_gen
// Purpose : Walking-ones payload pattern. Index 0 gives 0, index k in 1..64
//           gives 1<<(k-1), anything beyond 64 gives 0.
// Ports   : i_idx  [7:0]  payload flit index
//           o_flit [63:0] expected flit value
// Rev     : 1.0  initial release
// ============================================================================
module polara_loopback_pattern_gen (
  input  logic [7:0]  i_idx,
  output logic [63:0] o_flit
);

  always_comb begin
    o_flit = '0;
    if ((i_idx >= 8'd1) && (i_idx <= 8'd64)) begin
      o_flit = 64'h1 << (i_idx - 8'd1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/polara_loopback_packet_chk.sv
`default_nettype none
// ============================================================================
// Module  : polara_loopback_packet_chk
// Purpose : Receive-side checker for the Polara loopback test. Sinks packets
//           from the NoC chosen by sw_debounced, checks header chip ID,
//           message type and length, compares the payload against the
//           walking-ones pattern and reports sticky status.
// Ports   : chipset_clk, chip_rst (sync, active-high)
//           sw_debounced[1:0]  NoC select (0 none, 1..3 noc1..noc3)
//           march              expected length 65 (1) or 0 (0)
//           intf_chipset_data/val_noc1..3  flit inputs
//           chipset_intf_rdy_noc1..3       ready outputs
//           chk_done, chk_pass, err_hdr, err_len, err_data,
//           err_flit_idx[7:0], pkt_cnt[PKT_CNT_W-1:0]  status
// Rev     : 1.0  initial release
// ============================================================================
module polara_loopback_packet_chk
  import polara_loopback_pkg::*;
#(
  parameter logic [13:0] EXP_CHIPID   = polara_loopback_pkg::EXP_CHIPID,
  parameter logic [7:0]  EXP_MSG_TYPE = MSG_TYPE_INV_FWD,
  parameter int          PKT_CNT_W    = 16
) (
  input  logic                 chipset_clk,
  input  logic                 chip_rst,
  input  logic [1:0]           sw_debounced,
  input  logic                 march,
  input  logic [63:0]          intf_chipset_data_noc1,
  input  logic [63:0]          intf_chipset_data_noc2,
  input  logic [63:0]          intf_chipset_data_noc3,
  input  logic                 intf_chipset_val_noc1,
  input  logic                 intf_chipset_val_noc2,
  input  logic                 intf_chipset_val_noc3,
  output logic                 chipset_intf_rdy_noc1,
  output logic                 chipset_intf_rdy_noc2,
  output logic                 chipset_intf_rdy_noc3,
  output logic                 chk_done,
  output logic                 chk_pass,
  output logic                 err_hdr,
  output logic                 err_len,
  output logic                 err_data,
  output logic [7:0]           err_flit_idx,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  state_t               r_state;
  logic [1:0]           r_sel;
  logic [7:0]           r_rem;
  logic [7:0]           r_idx;
  logic                 r_done;
  logic                 r_err_hdr;
  logic                 r_err_len;
  logic                 r_err_data;
  logic [7:0]           r_err_idx;
  logic [PKT_CNT_W-1:0] r_cnt;

  logic [63:0] w_data;
  logic        w_val;
  logic        w_live;
  logic        w_acc;
  logic [63:0] w_exp_flit;
  logic [7:0]  w_len;
  logic [7:0]  w_len_exp;
  logic        w_hdr_bad;

  // Flit/valid mux on the frozen select; sel 0 masks every input.
  always_comb begin
    w_data = '0;
    w_val  = 1'b0;
    case (r_sel)
      2'd1: begin w_data = intf_chipset_data_noc1; w_val = intf_chipset_val_noc1; end
      2'd2: begin w_data = intf_chipset_data_noc2; w_val = intf_chipset_val_noc2; end
      2'd3: begin w_data = intf_chipset_data_noc3; w_val = intf_chipset_val_noc3; end
      default: begin w_data = '0; w_val = 1'b0; end
    endcase
  end

  assign w_live = (r_state == IDLE) || (r_state == DATA);
  assign w_acc  = w_val && w_live;

  assign chipset_intf_rdy_noc1 = w_live && (r_sel == 2'd1);
  assign chipset_intf_rdy_noc2 = w_live && (r_sel == 2'd2);
  assign chipset_intf_rdy_noc3 = w_live && (r_sel == 2'd3);

  assign w_len     = w_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign w_len_exp = march ? LOOPBACK_MARCH_LEN : 8'd0;
  assign w_hdr_bad = (w_data[HDR_CHIPID_MSB:HDR_CHIPID_LSB] != EXP_CHIPID) ||
                     (w_data[HDR_TYPE_MSB:HDR_TYPE_LSB] != EXP_MSG_TYPE);

  polara_loopback_pattern_gen u_pattern_gen (
    .i_idx  (r_idx),
    .o_flit (w_exp_flit)
  );

  always_ff @(posedge chipset_clk) begin
    if (chip_rst) begin
      r_state    <= IDLE;
      r_sel      <= 2'd0;
      r_rem      <= 8'd0;
      r_idx      <= 8'd0;
      r_done     <= 1'b0;
      r_err_hdr  <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_data <= 1'b0;
      r_err_idx  <= 8'd0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            // Select stays frozen from header acceptance until back in IDLE.
            r_rem <= w_len;
            r_idx <= 8'd0;
            if (w_hdr_bad)            r_err_hdr <= 1'b1;
            if (w_len != w_len_exp)   r_err_len <= 1'b1;
            if (w_len == 8'd0) begin
              r_done <= 1'b1;
              if (r_cnt != '1) r_cnt <= r_cnt + PKT_CNT_W'(1);
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_sel <= sw_debounced;
          end
        end
        DATA: begin
          if (w_acc) begin
            if (w_data != w_exp_flit) begin
              r_err_data <= 1'b1;
              if (!r_err_data) r_err_idx <= r_idx;
            end
            r_idx <= r_idx + 8'd1;
            r_rem <= r_rem - 8'd1;
            // Drain exactly len flits regardless of the expected length.
            if (r_rem == 8'd1) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              if (r_cnt != '1) r_cnt <= r_cnt + PKT_CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chk_done     = r_done;
  assign chk_pass     = r_done & ~(r_err_hdr | r_err_len | r_err_data);
  assign err_hdr      = r_err_hdr;
  assign err_len      = r_err_len;
  assign err_data     = r_err_data;
  assign err_flit_idx = r_err_idx;
  assign pkt_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_polara_loopback_packet_chk.sv
`default_nettype none
// ============================================================================
// Module  : tb_polara_loopback_packet_chk
// Purpose : Self-checking bench for polara_loopback_packet_chk. Directed
//           packets are driven on the NoC inputs; the status expected after
//           each completed packet is queued and compared by a monitor when
//           pkt_cnt advances.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_polara_loopback_packet_chk;

  logic        chipset_clk;
  logic        chip_rst;
  logic [1:0]  sw_debounced;
  logic        march;
  logic [63:0] data1, data2, data3;
  logic        val1, val2, val3;
  logic        rdy1, rdy2, rdy3;
  logic        chk_done, chk_pass, err_hdr, err_len, err_data;
  logic [7:0]  err_flit_idx;
  logic [15:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        pass;
    logic        hdr;
    logic        len;
    logic        data;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb_q[$];

  polara_loopback_packet_chk dut (
    .chipset_clk            (chipset_clk),
    .chip_rst               (chip_rst),
    .sw_debounced           (sw_debounced),
    .march                  (march),
    .intf_chipset_data_noc1 (data1),
    .intf_chipset_data_noc2 (data2),
    .intf_chipset_data_noc3 (data3),
    .intf_chipset_val_noc1  (val1),
    .intf_chipset_val_noc2  (val2),
    .intf_chipset_val_noc3  (val3),
    .chipset_intf_rdy_noc1  (rdy1),
    .chipset_intf_rdy_noc2  (rdy2),
    .chipset_intf_rdy_noc3  (rdy3),
    .chk_done               (chk_done),
    .chk_pass               (chk_pass),
    .err_hdr                (err_hdr),
    .err_len                (err_len),
    .err_data               (err_data),
    .err_flit_idx           (err_flit_idx),
    .pkt_cnt                (pkt_cnt)
  );

  initial chipset_clk = 1'b0;
  always #5 chipset_clk = ~chipset_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [13:0] cid, input logic [7:0] len,
                                      input logic [7:0] typ);
    hdr = {cid, 8'd0, 8'd0, 4'd0, len, typ, 8'd0, 6'd0};
  endfunction

  // Walking-ones reference: flit 0 = 0, flit k = 1<<(k-1).
  function automatic logic [63:0] pat(input int k);
    if (k == 0) pat = 64'd0;
    else if (k <= 64) pat = 64'd1 << (k - 1);
    else pat = 64'd0;
  endfunction

  function automatic logic rdy_of(input int n);
    case (n)
      1: rdy_of = rdy1;
      2: rdy_of = rdy2;
      3: rdy_of = rdy3;
      default: rdy_of = 1'b0;
    endcase
  endfunction

  task automatic drive(input int n, input logic [63:0] d, input logic v);
    val1 = 1'b0; val2 = 1'b0; val3 = 1'b0;
    case (n)
      1: begin data1 = d; val1 = v; end
      2: begin data2 = d; val2 = v; end
      3: begin data3 = d; val3 = v; end
      default: ;
    endcase
  endtask

  // Present one flit and hold it until the DUT takes it (bounded wait).
  task automatic send_flit(input int n, input logic [63:0] d);
    int waitc = 0;
    drive(n, d, 1'b1);
    @(negedge chipset_clk);
    while (!rdy_of(n)) begin
      waitc++;
      if (waitc > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: noc%0d rdy got 0, want 1", n);
        drive(n, 64'd0, 1'b0);
        return;
      end
      @(negedge chipset_clk);
    end
    @(posedge chipset_clk);
    #1;
    drive(n, 64'd0, 1'b0);
  endtask

  task automatic gap(input int g);
    repeat (g) @(posedge chipset_clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] c, input logic p, input logic h,
                          input logic l, input logic dd, input logic [7:0] ix);
    exp_t e;
    e.cnt = c; e.pass = p; e.hdr = h; e.len = l; e.data = dd; e.idx = ix;
    sb_q.push_back(e);
  endtask

  // Monitor: each pkt_cnt advance is one completed packet.
  logic [15:0] prev_cnt = 16'd0;
  always @(negedge chipset_clk) begin
    if (chip_rst) begin
      prev_cnt = 16'd0;
    end else if (pkt_cnt !== prev_cnt) begin
      exp_t e;
      prev_cnt = pkt_cnt;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: pkt_cnt got %0h, want no completion", pkt_cnt);
      end else begin
        e = sb_q.pop_front();
        check("sb_pkt_cnt",  pkt_cnt,      e.cnt);
        check("sb_done",     chk_done,     1'b1);
        check("sb_pass",     chk_pass,     e.pass);
        check("sb_err_hdr",  err_hdr,      e.hdr);
        check("sb_err_len",  err_len,      e.len);
        check("sb_err_data", err_data,     e.data);
        check("sb_flit_idx", err_flit_idx, e.idx);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  chk_done,     1'b0);
    check({tag, "_pass"},  chk_pass,     1'b0);
    check({tag, "_hdr"},   err_hdr,      1'b0);
    check({tag, "_len"},   err_len,      1'b0);
    check({tag, "_data"},  err_data,     1'b0);
    check({tag, "_idx"},   err_flit_idx, 8'd0);
    check({tag, "_cnt"},   pkt_cnt,      16'd0);
    check({tag, "_rdy"},   {rdy1, rdy2, rdy3}, 3'b000);
  endtask

  initial begin
    chip_rst = 1'b1;
    sw_debounced = 2'd0;
    march = 1'b0;
    data1 = '0; data2 = '0; data3 = '0;
    val1 = 1'b0; val2 = 1'b0; val3 = 1'b0;

    // Reset state
    repeat (3) @(posedge chipset_clk);
    @(negedge chipset_clk);
    check_all_zero("reset");
    @(posedge chipset_clk); #1;
    chip_rst = 1'b0;

    // Header-only packet on noc2
    sw_debounced = 2'd2;
    march = 1'b0;
    gap(2);
    @(negedge chipset_clk);
    check("t1_rdy_sel2", {rdy1, rdy2, rdy3}, 3'b010);
    gap(1);
    push_exp(16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send_flit(2, hdr(14'b10000000000000, 8'd0, 8'd18));
    @(negedge chipset_clk);
    check("t1_rdy_others", {rdy1, rdy3}, 2'b00);
    gap(1);

    // Clean 65-flit march packet on noc1 with random valid gaps
    sw_debounced = 2'd1;
    march = 1'b1;
    gap(2);
    push_exp(16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send_flit(1, hdr(14'b10000000000000, 8'd65, 8'd18));
    for (int k = 0; k < 65; k++) begin
      gap($urandom_range(0, 2));
      send_flit(1, pat(k));
    end
    @(negedge chipset_clk);
    check("t2_rdy_idle", rdy1, 1'b1);
    gap(1);

    // Flit 5 and flit 9 corrupted; only the first is recorded
    push_exp(16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    send_flit(1, hdr(14'b10000000000000, 8'd65, 8'd18));
    for (int k = 0; k < 65; k++) begin
      if (k == 5)      send_flit(1, 64'h20);
      else if (k == 9) send_flit(1, 64'h0);
      else             send_flit(1, pat(k));
    end
    gap(1);

    // Wrong length (3): drained after exactly 3 flits
    push_exp(16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    send_flit(1, hdr(14'b10000000000000, 8'd3, 8'd18));
    send_flit(1, 64'h0);
    send_flit(1, 64'h1);
    send_flit(1, 64'h2);
    @(negedge chipset_clk);
    check("t4_cnt_after_3", pkt_cnt, 16'd4);
    check("t4_rdy_idle", rdy1, 1'b1);
    gap(1);
    // Next header right away, wrong message type
    march = 1'b0;
    push_exp(16'd5, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    send_flit(1, hdr(14'b10000000000000, 8'd0, 8'd19));
    gap(1);

    // Select flipped from 3 to 1 mid-payload
    march = 1'b1;
    sw_debounced = 2'd3;
    gap(2);
    push_exp(16'd6, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    send_flit(3, hdr(14'b10000000000000, 8'd65, 8'd18));
    for (int k = 0; k < 10; k++) send_flit(3, pat(k));
    sw_debounced = 2'd1;
    @(negedge chipset_clk);
    check("t5_rdy_mid", {rdy1, rdy3}, 2'b01);
    gap(1);
    for (int k = 10; k < 65; k++) send_flit(3, pat(k));
    repeat (2) @(negedge chipset_clk);
    check("t5_rdy_after", {rdy1, rdy3}, 2'b10);
    gap(1);

    // Reset at payload flit 30, then a clean packet
    send_flit(1, hdr(14'b10000000000000, 8'd65, 8'd18));
    for (int k = 0; k < 30; k++) send_flit(1, pat(k));
    chip_rst = 1'b1;
    @(posedge chipset_clk);
    @(negedge chipset_clk);
    check_all_zero("t6_rst");
    @(posedge chipset_clk); #1;
    chip_rst = 1'b0;
    gap(2);
    push_exp(16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send_flit(1, hdr(14'b10000000000000, 8'd65, 8'd18));
    for (int k = 0; k < 65; k++) send_flit(1, pat(k));
    gap(3);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
